timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Control FSM for the MM:SS egg-timer countdown. Owns the 1 Hz tick prescaler, start/pause/clear sequencing and the alarm phase.
- Drives four cascaded BCD digit counters (sec ones, sec tens, min ones, min tens): per-digit enables and a preset-load strobe.
- Consumes each counter's zero flag to generate borrows and to detect expiry.

Parameters:
- TICK_DIV, 1000000: clk cycles per countdown tick (1 s at 1 MHz). Must be ≥ 2.
- ALARM_SECS, 10: ticks spent in ALARM before auto-return to IDLE. Must be ≥ 1.
- PW, $clog2(TICK_DIV): prescaler width. Derived; not overridden.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- start_stop, input, 1: debounced single-cycle pulse; start, pause or resume.
- clear, input, 1: debounced single-cycle pulse; abort and reload preset.
- zero, input, 4: zero flags from the digit counters, [0]=sec ones … [3]=min tens.
- digit_en, output, 4: per-digit decrement enables, same bit order as zero.
- counter_load, output, 1: registered one-cycle strobe that reloads the preset into all counters.
- running, output, 1: high in RUN.
- alarm, output, 1: high in ALARM.
- state, output, 2: current state code, for debug.

Behaviour:
- Reset values: state=IDLE, prescaler=0, tick=0, counter_load=0, alarm=0, running=0, alarm counter=0. digit_en=0 while in reset.
- States: IDLE=0, RUN=1, PAUSE=2, ALARM=3. all_zero = &zero.
- Priority within a cycle: clear > start_stop > tick.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and ALARM; holds in PAUSE.
  - tick is a registered one-cycle pulse asserted the cycle after the count reaches TICK_DIV-1; count wraps to 0.
  - Prescaler and tick clear on IDLE→RUN and on entry to ALARM.
  - PAUSE→RUN resumes from the held value, so a partial second is not lost.
- digit_en (combinational from registered state and tick and the zero input):
  - Let t = tick & (state==RUN) & ~all_zero & ~start_stop & ~clear.
  - en[0]=t; en[1]=t&zero[0]; en[2]=t&zero[0]&zero[1]; en[3]=t&zero[0]&zero[1]&zero[2].
- IDLE:
  - clear → counter_load next cycle; stay IDLE.
  - start_stop & ~all_zero → RUN.
  - start_stop & all_zero → ignored; stay IDLE.
- RUN:
  - clear → counter_load; go to IDLE.
  - start_stop → PAUSE. No enable that cycle, even if tick coincides.
  - tick & all_zero → ALARM. All digit_en=0, so counters never wrap past 00:00.
- PAUSE:
  - start_stop → RUN.
  - clear → counter_load; go to IDLE.
  - digit_en=0 throughout.
- ALARM:
  - alarm=1. An alarm counter counts ticks.
  - After ALARM_SECS ticks, or on start_stop or clear → counter_load; go to IDLE.
- counter_load:
  - Exactly one cycle, registered (glitch-free), asserted on the cycle after the state transition.
  - Drives the counters' reset/load pin, OR'd externally with the system reset.
  - Consecutive clears each produce one strobe.
- running and alarm are registered state decodes.
- Asynchronous reset at any point (mid-RUN, mid-ALARM) forces all reset values immediately. No counter_load is generated, because the counters reload on reset themselves.

Decomposition:
- Shared package timer_pkg holds:
  - the state encoding (localparams S_IDLE, S_RUN, S_PAUSE, S_ALARM);
  - digit index constants (SEC_ONES=0 … MIN_TENS=3);
  - default TICK_DIV and ALARM_SECS.
- One sub-module, tick_prescaler: enable, sync clear, PW-bit counter, registered tick output. The FSM, borrow cascade, alarm counter and load strobe stay in timer_sequencer.

Test Plan:
The bench uses TICK_DIV=4, ALARM_SECS=2, with four real digit counters (MAX 9,5,9,5) preset 00:03.
- Countdown to expiry: start_stop pulse → display 00:02, 00:01, 00:00 on the first three ticks. On the 4th tick: ALARM, alarm=1, digit_en never 4'b0001 at 00:00. After 2 more ticks: one-cycle counter_load, IDLE, display 00:03.
- Borrow cascade, preset 01:00, RUN: on the first tick digit_en=4'b0111 and display becomes 00:59. At 10:00 → digit_en=4'b1111 → 09:59.
- Pause/resume: start_stop after 1.5 ticks → PAUSE. Hold 40 cycles: digit_en=0 and prescaler frozen. Resume: the next tick arrives 2 cycles later, not 4.
- Collision: start_stop on the same cycle as tick → PAUSE, digit_en=0, display unchanged. clear together with start_stop in RUN → IDLE plus one counter_load.
- Zero start: load preset 00:00, start_stop → state stays IDLE, running=0, no tick.
- Async reset mid-RUN at 00:01 → state=0, alarm=0, running=0, counter_load=0 immediately (same cycle, before the clock edge). Counters reload the preset; a subsequent start_stop counts normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the egg-timer sequencer: state codes, digit indices and defaults.
package timer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StRun   = S_RUN,
    StPause = S_PAUSE,
    StAlarm = S_ALARM
  } state_e;

  localparam int unsigned SEC_ONES = 0;
  localparam int unsigned SEC_TENS = 1;
  localparam int unsigned MIN_ONES = 2;
  localparam int unsigned MIN_TENS = 3;

  localparam int unsigned DEFAULT_TICK_DIV   = 1000000;
  localparam int unsigned DEFAULT_ALARM_SECS = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle countdown tick; holds its count while disabled.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned PW       = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [PW-1:0] Last = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == Last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/timer_sequencer.sv
// MM:SS countdown control: start/pause/clear FSM, borrow cascade, alarm phase and load strobe.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int unsigned ALARM_SECS = DEFAULT_ALARM_SECS,
  localparam int unsigned PW        = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_i,
  input  logic       clear_i,
  input  logic [3:0] zero_i,
  output logic [3:0] digit_en_o,
  output logic       counter_load_o,
  output logic       running_o,
  output logic       alarm_o,
  output logic [1:0] state_o
);

  localparam int unsigned AW = $clog2(ALARM_SECS + 1);
  localparam logic [AW-1:0] AlarmLast = AW'(ALARM_SECS - 1);

  state_e        state_q, state_d;
  logic          load_q, load_d;
  logic          running_q, alarm_q;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          tick, all_zero, presc_en, presc_clr, t;

  assign all_zero = &zero_i;

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    acnt_d  = acnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          load_d = 1'b1;
        end else if (start_stop_i && !all_zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (clear_i) begin
          load_d  = 1'b1;
          state_d = StIdle;
        end else if (start_stop_i) begin
          state_d = StPause;
        end else if (tick && all_zero) begin
          state_d = StAlarm;
          acnt_d  = '0;
        end
      end
      StPause: begin
        if (clear_i) begin
          load_d  = 1'b1;
          state_d = StIdle;
        end else if (start_stop_i) begin
          state_d = StRun;
        end
      end
      StAlarm: begin
        if (clear_i || start_stop_i) begin
          load_d  = 1'b1;
          state_d = StIdle;
        end else if (tick) begin
          if (acnt_q == AlarmLast) begin
            load_d  = 1'b1;
            state_d = StIdle;
          end else begin
            acnt_d = acnt_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A cycle consumed by start_stop/clear does not advance the prescaler, so a pause
  // freezes the partial second exactly where it was.
  assign presc_en  = ((state_q == StRun) && !start_stop_i && !clear_i) || (state_q == StAlarm);
  assign presc_clr = ((state_q == StIdle) && (state_d == StRun)) ||
                     ((state_q == StRun) && (state_d == StAlarm));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PW       (PW)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  assign t = tick && (state_q == StRun) && !all_zero && !start_stop_i && !clear_i;

  always_comb begin
    digit_en_o           = '0;
    digit_en_o[SEC_ONES] = t;
    digit_en_o[SEC_TENS] = t && zero_i[SEC_ONES];
    digit_en_o[MIN_ONES] = t && zero_i[SEC_ONES] && zero_i[SEC_TENS];
    digit_en_o[MIN_TENS] = t && zero_i[SEC_ONES] && zero_i[SEC_TENS] && zero_i[MIN_ONES];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      load_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      acnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      running_q <= (state_d == StRun);
      alarm_q   <= (state_d == StAlarm);
      acnt_q    <= acnt_d;
    end
  end

  assign counter_load_o = load_q;
  assign running_o      = running_q;
  assign alarm_o        = alarm_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench: sequencer driving four BCD digit counters (max 9,5,9,5), TICK_DIV=4, ALARM_SECS=2.
module tb_timer_sequencer;

  logic        clk;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic [3:0]  zero;
  logic [3:0]  digit_en;
  logic        counter_load;
  logic        running;
  logic        alarm;
  logic [1:0]  state;

  logic [15:0] preset;
  logic [15:0] disp;
  wire  [15:0] dmax = 16'h5959;
  wire         cnt_rst = reset | counter_load;

  int n_vec = 0;
  int n_err = 0;
  int load_hi = 0;
  int wrap_bad = 0;
  int pause_bad = 0;
  int lc0;

  timer_sequencer #(
    .TICK_DIV   (4),
    .ALARM_SECS (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_stop_i   (start_stop),
    .clear_i        (clear),
    .zero_i         (zero),
    .digit_en_o     (digit_en),
    .counter_load_o (counter_load),
    .running_o      (running),
    .alarm_o        (alarm),
    .state_o        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit counters: decrement on enable, wrap 0 -> max, reload preset on reset/load.
  always_ff @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      disp <= preset;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (digit_en[i]) begin
          disp[4*i +: 4] <= (disp[4*i +: 4] == 4'd0) ? dmax[4*i +: 4] : disp[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    zero = '0;
    for (int i = 0; i < 4; i++) zero[i] = (disp[4*i +: 4] == 4'd0);
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (counter_load) load_hi++;
      if (disp == 16'h0000 && digit_en != 4'b0000) wrap_bad++;
      if (state == 2'd2 && digit_en != 4'b0000) pause_bad++;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic load_preset(input logic [15:0] p);
    preset = p;
    pulse_clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    preset     = 16'h0003;
    step(3);
    check_eq("rst_state", 16'(state), 16'd0);
    check_eq("rst_running", 16'(running), 16'd0);
    check_eq("rst_alarm", 16'(alarm), 16'd0);
    check_eq("rst_load", 16'(counter_load), 16'd0);
    check_eq("rst_en", 16'(digit_en), 16'd0);
    check_eq("rst_disp", disp, 16'h0003);
    reset = 1'b0;
    step(1);

    // Countdown 00:03 to expiry, then alarm phase and auto-return.
    pulse_ss();
    check_eq("cd_state_run", 16'(state), 16'd1);
    check_eq("cd_running", 16'(running), 16'd1);
    step(4);
    check_eq("cd_en_tick1", 16'(digit_en), 16'h1);
    step(1);
    check_eq("cd_disp_0002", disp, 16'h0002);
    step(4);
    check_eq("cd_disp_0001", disp, 16'h0001);
    step(4);
    check_eq("cd_disp_0000", disp, 16'h0000);
    step(3);
    check_eq("cd_en_at_zero", 16'(digit_en), 16'h0);
    step(1);
    check_eq("cd_state_alarm", 16'(state), 16'd3);
    check_eq("cd_alarm", 16'(alarm), 16'd1);
    check_eq("cd_running_off", 16'(running), 16'd0);
    step(8);
    check_eq("cd_still_alarm", 16'(state), 16'd3);
    check_eq("cd_no_load_yet", 16'(counter_load), 16'd0);
    step(1);
    check_eq("cd_state_idle", 16'(state), 16'd0);
    check_eq("cd_load", 16'(counter_load), 16'd1);
    check_eq("cd_alarm_off", 16'(alarm), 16'd0);
    check_eq("cd_disp_reload", disp, 16'h0003);
    step(1);
    check_eq("cd_load_1cyc", 16'(counter_load), 16'd0);

    // Borrow cascade.
    load_preset(16'h0100);
    check_eq("bc_load", 16'(counter_load), 16'd1);
    check_eq("bc_disp_0100", disp, 16'h0100);
    step(1);
    pulse_ss();
    step(4);
    check_eq("bc_en_0111", 16'(digit_en), 16'h7);
    step(1);
    check_eq("bc_disp_0059", disp, 16'h0059);
    pulse_clr();
    check_eq("bc_clr_idle", 16'(state), 16'd0);
    check_eq("bc_clr_load", 16'(counter_load), 16'd1);
    check_eq("bc_clr_disp", disp, 16'h0100);
    step(1);
    load_preset(16'h1000);
    step(1);
    pulse_ss();
    step(4);
    check_eq("bc_en_1111", 16'(digit_en), 16'hf);
    step(1);
    check_eq("bc_disp_0959", disp, 16'h0959);
    pulse_clr();
    step(1);

    // Back-to-back clears in IDLE give one strobe each.
    lc0 = load_hi;
    pulse_clr();
    step(1);
    pulse_clr();
    step(1);
    check_eq("dbl_clear_strobes", 16'(load_hi - lc0), 16'd2);

    // Pause after 1.5 ticks, hold, resume with the partial second kept.
    load_preset(16'h0003);
    step(1);
    pulse_ss();
    step(6);
    pulse_ss();
    check_eq("pr_state_pause", 16'(state), 16'd2);
    check_eq("pr_running_off", 16'(running), 16'd0);
    check_eq("pr_disp", disp, 16'h0002);
    step(40);
    check_eq("pr_hold_state", 16'(state), 16'd2);
    check_eq("pr_hold_disp", disp, 16'h0002);
    check_eq("pr_no_en", 16'(pause_bad), 16'd0);
    pulse_ss();
    check_eq("pr_resume_run", 16'(state), 16'd1);
    check_eq("pr_en_r1", 16'(digit_en), 16'h0);
    step(1);
    check_eq("pr_en_r2", 16'(digit_en), 16'h0);
    step(1);
    check_eq("pr_tick_r3", 16'(digit_en), 16'h1);
    step(1);
    check_eq("pr_disp_0001", disp, 16'h0001);

    // start_stop coinciding with a tick.
    step(3);
    check_eq("col_tick_seen", 16'(digit_en), 16'h1);
    start_stop = 1'b1;
    #1;
    check_eq("col_en_killed", 16'(digit_en), 16'h0);
    step(1);
    start_stop = 1'b0;
    check_eq("col_state_pause", 16'(state), 16'd2);
    check_eq("col_disp_hold", disp, 16'h0001);
    pulse_ss();
    lc0 = load_hi;
    clear      = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear      = 1'b0;
    start_stop = 1'b0;
    check_eq("col_clr_idle", 16'(state), 16'd0);
    check_eq("col_clr_load", 16'(counter_load), 16'd1);
    step(1);
    check_eq("col_one_strobe", 16'(load_hi - lc0), 16'd1);
    check_eq("col_disp_reload", disp, 16'h0003);

    // Start with 00:00 loaded is ignored.
    load_preset(16'h0000);
    step(1);
    pulse_ss();
    check_eq("zs_state", 16'(state), 16'd0);
    check_eq("zs_running", 16'(running), 16'd0);
    step(6);
    check_eq("zs_state_later", 16'(state), 16'd0);
    check_eq("zs_disp", disp, 16'h0000);

    // Asynchronous reset mid-run at 00:01.
    load_preset(16'h0003);
    step(1);
    pulse_ss();
    step(9);
    check_eq("ar_disp_0001", disp, 16'h0001);
    step(1);
    reset = 1'b1;
    #1;
    check_eq("ar_state", 16'(state), 16'd0);
    check_eq("ar_alarm", 16'(alarm), 16'd0);
    check_eq("ar_running", 16'(running), 16'd0);
    check_eq("ar_load", 16'(counter_load), 16'd0);
    check_eq("ar_disp", disp, 16'h0003);
    step(1);
    reset = 1'b0;
    step(1);
    pulse_ss();
    step(4);
    check_eq("ar_en_tick1", 16'(digit_en), 16'h1);
    step(1);
    check_eq("ar_disp_0002", disp, 16'h0002);

    check_eq("no_wrap_at_zero", 16'(wrap_bad), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
